video_timing_gen: RTL

- Parametrised raster timing generator, successor to the fixed 720x480 generator in the display path.
- Produces hs, vs, de and pixel coordinates for any CEA/VESA-style timing set by parameters.
- Adds a runtime-programmable sub-window with its own enable and relative coordinates (letterboxing smaller panels/framebuffers), frame/line markers, and a clock-enable for pixel-rate division.
- Sits between the pixel-clock domain and the framebuffer reader / TMDS encoder.

---
 rtl/video_timing_pkg.sv | 50 +++++
 rtl/video_timing_gen_timing_axis.sv | 57 +++++
 rtl/video_timing_gen.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/video_timing_pkg.sv
// Shared timing presets and elaboration helpers for the raster timing generator.
package video_timing_pkg;

  typedef struct packed {
    int unsigned h_active;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
    int unsigned v_active;
    int unsigned v_fp;
    int unsigned v_sync;
    int unsigned v_bp;
    logic        hs_pol;
    logic        vs_pol;
  } timing_t;

  localparam timing_t Timing480p = '{
    h_active: 720,  h_fp: 16,  h_sync: 62, h_bp: 60,
    v_active: 480,  v_fp: 9,   v_sync: 6,  v_bp: 30,
    hs_pol: 1'b0, vs_pol: 1'b0
  };

  localparam timing_t Timing720p = '{
    h_active: 1280, h_fp: 110, h_sync: 40, h_bp: 220,
    v_active: 720,  v_fp: 5,   v_sync: 5,  v_bp: 20,
    hs_pol: 1'b1, vs_pol: 1'b1
  };

  localparam timing_t Timing1080p = '{
    h_active: 1920, h_fp: 88,  h_sync: 44, h_bp: 148,
    v_active: 1080, v_fp: 4,   v_sync: 5,  v_bp: 36,
    hs_pol: 1'b1, vs_pol: 1'b1
  };

  localparam timing_t Timing480x272 = '{
    h_active: 480,  h_fp: 2,   h_sync: 41, h_bp: 2,
    v_active: 272,  v_fp: 2,   v_sync: 10, v_bp: 2,
    hs_pol: 1'b0, vs_pol: 1'b0
  };

  function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic bit total_fits(input int unsigned total, input int unsigned width);
    return longint'(total) < (longint'(1) << width);
  endfunction

endpackage

// File: rtl/video_timing_gen_timing_axis.sv
// One raster axis: wrapping counter plus sync, active-span and coordinate decodes.
module timing_axis
  import video_timing_pkg::*;
#(
  parameter int unsigned CNT_W  = 12,
  parameter int unsigned ACTIVE = 720,
  parameter int unsigned FP     = 16,
  parameter int unsigned SYNC   = 62,
  parameter int unsigned BP     = 60,
  parameter bit          POL    = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             step_i,
  output logic             wrap_o,
  output logic             sync_o,
  output logic             act_o,
  output logic [CNT_W-1:0] coord_o
);

  localparam int unsigned Total = axis_total(ACTIVE, FP, SYNC, BP);
  localparam int unsigned Start = SYNC + BP;
  localparam logic [CNT_W-1:0] Last = CNT_W'(Total - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   rel;

  always_comb begin
    wrap_o = step_i && (cnt_q == Last);
    cnt_d  = cnt_q;
    if (step_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Extra bit makes counts below the span start wrap high, so one compare covers both edges.
  always_comb begin
    rel     = {1'b0, cnt_q} - (CNT_W + 1)'(Start);
    act_o   = rel < (CNT_W + 1)'(ACTIVE);
    coord_o = rel[CNT_W-1:0];
  end

  if (SYNC == 0) begin : g_no_sync
    assign sync_o = ~POL;
  end else begin : g_sync
    assign sync_o = (cnt_q < CNT_W'(SYNC)) ? POL : ~POL;
  end

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator with a frame-shadowed sub-window and line/frame markers.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned CNT_W      = 12,
  parameter int unsigned H_ACTIVE   = 720,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 62,
  parameter int unsigned H_BP       = 60,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 9,
  parameter int unsigned V_SYNC     = 6,
  parameter int unsigned V_BP       = 30,
  parameter bit          HS_POL     = 1'b1,
  parameter bit          VS_POL     = 1'b1,
  parameter int unsigned WIN_X0_RST = 0,
  parameter int unsigned WIN_Y0_RST = 0,
  parameter int unsigned WIN_W_RST  = 480,
  parameter int unsigned WIN_H_RST  = 272
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] win_x0,
  input  logic [CNT_W-1:0] win_y0,
  input  logic [CNT_W-1:0] win_w,
  input  logic [CNT_W-1:0] win_h,
  output logic             hs,
  output logic             vs,
  output logic             de,
  output logic [CNT_W-1:0] active_x,
  output logic [CNT_W-1:0] active_y,
  output logic             win_de,
  output logic [CNT_W-1:0] win_x,
  output logic [CNT_W-1:0] win_y,
  output logic             sof,
  output logic             eol
);

  localparam int unsigned HTotal = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned VTotal = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (!total_fits(HTotal, CNT_W)) begin : g_h_overflow
    $fatal(1, "horizontal total does not fit in CNT_W");
  end
  if (!total_fits(VTotal, CNT_W)) begin : g_v_overflow
    $fatal(1, "vertical total does not fit in CNT_W");
  end

  logic             h_wrap, h_sync, h_act;
  logic             v_wrap, v_sync, v_act;
  logic [CNT_W-1:0] x_c, y_c;

  timing_axis #(
    .CNT_W  (CNT_W),
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (HS_POL)
  ) u_h_axis (
    .clk_i   (clk),
    .rst_i   (rst),
    .step_i  (en),
    .wrap_o  (h_wrap),
    .sync_o  (h_sync),
    .act_o   (h_act),
    .coord_o (x_c)
  );

  timing_axis #(
    .CNT_W  (CNT_W),
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (VS_POL)
  ) u_v_axis (
    .clk_i   (clk),
    .rst_i   (rst),
    .step_i  (h_wrap & en),
    .wrap_o  (v_wrap),
    .sync_o  (v_sync),
    .act_o   (v_act),
    .coord_o (y_c)
  );

  logic             hs_q, hs_d, vs_q, vs_d, de_q, de_d;
  logic             win_de_q, win_de_d, sof_q, sof_d, eol_q, eol_d;
  logic [CNT_W-1:0] active_x_q, active_x_d, active_y_q, active_y_d;
  logic [CNT_W-1:0] win_x_q, win_x_d, win_y_q, win_y_d;
  logic [CNT_W-1:0] wx0_q, wx0_d, wy0_q, wy0_d, ww_q, ww_d, wh_q, wh_d;

  logic             de_c, in_x, in_y, win_c;
  logic [CNT_W:0]   x_ext, y_ext, x0_ext, y0_ext;

  always_comb begin
    de_c   = h_act & v_act;
    x_ext  = {1'b0, x_c};
    y_ext  = {1'b0, y_c};
    x0_ext = {1'b0, wx0_q};
    y0_ext = {1'b0, wy0_q};
    // Bounds summed one bit wider so a window near the top of the range cannot wrap to zero.
    in_x   = (x_ext >= x0_ext) && (x_ext < (x0_ext + {1'b0, ww_q}));
    in_y   = (y_ext >= y0_ext) && (y_ext < (y0_ext + {1'b0, wh_q}));
    win_c  = de_c & in_x & in_y;

    hs_d       = hs_q;
    vs_d       = vs_q;
    de_d       = de_q;
    active_x_d = active_x_q;
    active_y_d = active_y_q;
    win_de_d   = win_de_q;
    win_x_d    = win_x_q;
    win_y_d    = win_y_q;
    sof_d      = sof_q;
    eol_d      = eol_q;
    wx0_d      = wx0_q;
    wy0_d      = wy0_q;
    ww_d       = ww_q;
    wh_d       = wh_q;

    if (en) begin
      hs_d     = h_sync;
      vs_d     = v_sync;
      de_d     = de_c;
      win_de_d = win_c;
      sof_d    = de_c && (x_c == '0) && (y_c == '0);
      eol_d    = de_c && (x_c == CNT_W'(H_ACTIVE - 1));
      if (h_act) begin
        active_x_d = x_c;
      end
      if (v_act) begin
        active_y_d = y_c;
      end
      if (win_c) begin
        win_x_d = x_c - wx0_q;
        win_y_d = y_c - wy0_q;
      end
    end

    // Geometry only moves on the last pixel of the frame so a frame never sees a torn window.
    if (v_wrap) begin
      wx0_d = win_x0;
      wy0_d = win_y0;
      ww_d  = win_w;
      wh_d  = win_h;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_q       <= ~HS_POL;
      vs_q       <= ~VS_POL;
      de_q       <= 1'b0;
      active_x_q <= '0;
      active_y_q <= '0;
      win_de_q   <= 1'b0;
      win_x_q    <= '0;
      win_y_q    <= '0;
      sof_q      <= 1'b0;
      eol_q      <= 1'b0;
      wx0_q      <= CNT_W'(WIN_X0_RST);
      wy0_q      <= CNT_W'(WIN_Y0_RST);
      ww_q       <= CNT_W'(WIN_W_RST);
      wh_q       <= CNT_W'(WIN_H_RST);
    end else begin
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      de_q       <= de_d;
      active_x_q <= active_x_d;
      active_y_q <= active_y_d;
      win_de_q   <= win_de_d;
      win_x_q    <= win_x_d;
      win_y_q    <= win_y_d;
      sof_q      <= sof_d;
      eol_q      <= eol_d;
      wx0_q      <= wx0_d;
      wy0_q      <= wy0_d;
      ww_q       <= ww_d;
      wh_q       <= wh_d;
    end
  end

  assign hs       = hs_q;
  assign vs       = vs_q;
  assign de       = de_q;
  assign active_x = active_x_q;
  assign active_y = active_y_q;
  assign win_de   = win_de_q;
  assign win_x    = win_x_q;
  assign win_y    = win_y_q;
  assign sof      = sof_q;
  assign eol      = eol_q;

endmodule
